control_sequencer: RTL

//  Hardwired control unit; drives the Datapath control inputs that benches drive by hand today.

---
 rtl/control_sequencer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-step control unit for register-register ALU instructions.
// Define SINGLE_STEP_EN to park in PAUSE after every instruction until a step pulse.
module control_sequencer #(
    parameter int NREG = 16,
    parameter int OPW  = 5,
    parameter int NOPS = 13
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     IR,
    input  logic            mem_ready,
    input  logic            run_req,
    input  logic            step,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic [NOPS-1:0] alu_ops,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            MDMuxread,
    output logic            IRin,
    output logic            Yin,
    output logic            Zlowin,
    output logic            Zhighin,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            HIin,
    output logic            LOin,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    localparam int RW = 4;

    localparam logic [OPW-1:0] OP_NEG      = OPW'(9);
    localparam logic [OPW-1:0] OP_NOT      = OPW'(10);
    localparam logic [OPW-1:0] OP_MUL      = OPW'(11);
    localparam logic [OPW-1:0] OP_DIV      = OPW'(12);
    localparam logic [OPW-1:0] OP_LAST_ALU = OPW'(NOPS - 1);
    localparam logic [OPW-1:0] OP_NOP      = OPW'(24);
    localparam logic [OPW-1:0] OP_HALT     = OPW'(25);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
`ifdef SINGLE_STEP_EN
        , S_PAUSE = 4'd9
`endif
    } state_t;

    state_t         state;
    state_t         next_state;
    state_t         done_state;

    logic [OPW-1:0] ir_op;
    logic [RW-1:0]  ir_rb;
    logic [OPW-1:0] op_q;
    logic [RW-1:0]  ra_q;
    logic [RW-1:0]  rc_q;
    logic           illegal_q;

    function automatic logic op_is_alu(input logic [OPW-1:0] op);
        return op <= OP_LAST_ALU;
    endfunction

    function automatic logic op_is_unary(input logic [OPW-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic op_is_wide(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_legal(input logic [OPW-1:0] op);
        return op_is_alu(op) || (op == OP_NOP) || (op == OP_HALT);
    endfunction

    function automatic logic [NREG-1:0] reg_sel(input logic [RW-1:0] r);
        return NREG'(1) << r;
    endfunction

    function automatic logic [NOPS-1:0] op_sel(input logic [OPW-1:0] op);
        return NOPS'(1) << op;
    endfunction

    assign ir_op = IR[31 -: OPW];
    assign ir_rb = IR[22:19];

`ifdef SINGLE_STEP_EN
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[14:0];
    assign done_state     = S_PAUSE;
`else
    logic unused_inputs;
    assign unused_inputs = ^{IR[14:0], step};
    assign done_state    = run_req ? S_T0 : S_IDLE;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // T3 is the first cycle the datapath IR is valid; later steps use this snapshot.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            op_q      <= '0;
            ra_q      <= '0;
            rc_q      <= '0;
            illegal_q <= 1'b0;
        end else if (state == S_T3) begin
            op_q <= ir_op;
            ra_q <= IR[26:23];
            rc_q <= IR[18:15];
            if (!op_is_legal(ir_op)) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        Rin        = '0;
        Rout       = '0;
        alu_ops    = '0;
        PCout      = 1'b0;
        PCin       = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        MDMuxread  = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zlowin     = 1'b0;
        Zhighin    = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        illegal    = illegal_q;

        case (state)
            S_IDLE: begin
                if (run_req) begin
                    next_state = S_T0;
                end
            end

            S_T0: begin
                busy       = 1'b1;
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zlowin     = 1'b1;
                next_state = S_T1;
            end

            // Loads are gated by mem_ready so PC and MDR update exactly once per fetch.
            S_T1: begin
                busy      = 1'b1;
                MDMuxread = 1'b1;
                if (mem_ready) begin
                    Zlowout    = 1'b1;
                    PCin       = 1'b1;
                    MDRin      = 1'b1;
                    next_state = S_T2;
                end
            end

            S_T2: begin
                busy       = 1'b1;
                MDRout     = 1'b1;
                IRin       = 1'b1;
                next_state = S_T3;
            end

            S_T3: begin
                busy = 1'b1;
                if (op_is_alu(ir_op)) begin
                    Rout = reg_sel(ir_rb);
                    if (op_is_unary(ir_op)) begin
                        alu_ops    = op_sel(ir_op);
                        Zlowin     = 1'b1;
                        next_state = S_T5;
                    end else begin
                        Yin        = 1'b1;
                        next_state = S_T4;
                    end
                end else if (ir_op == OP_HALT) begin
                    next_state = S_HALT;
                end else begin
                    next_state = done_state;
                end
            end

            S_T4: begin
                busy       = 1'b1;
                Rout       = reg_sel(rc_q);
                alu_ops    = op_sel(op_q);
                Zlowin     = 1'b1;
                Zhighin    = op_is_wide(op_q);
                next_state = S_T5;
            end

            S_T5: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                if (op_is_wide(op_q)) begin
                    LOin       = 1'b1;
                    next_state = S_T6;
                end else begin
                    Rin        = reg_sel(ra_q);
                    next_state = done_state;
                end
            end

            S_T6: begin
                busy       = 1'b1;
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                next_state = done_state;
            end

            S_HALT: begin
                halted = 1'b1;
            end

`ifdef SINGLE_STEP_EN
            S_PAUSE: begin
                if (step) begin
                    next_state = S_T0;
                end
            end
`endif

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule
